// File: rtl/non_max_suppression.sv
// non_max_suppression: Canny non-maximum suppression over a raster stream of
// gradient magnitude plus 2-bit quantized direction. Two line buffers feed a
// 3x3 window; the centre survives only if it is a local maximum along its
// gradient direction. Optional feature macro: NMS_THRESH_EN (adds a
// LOW_THRESH floor on surviving magnitudes).
module non_max_suppression #(
  parameter int              NBIT       = 16,
  parameter int              IMG_WIDTH  = 640,
  parameter int              IMG_HEIGHT = 480,
  parameter logic [NBIT-1:0] LOW_THRESH = {NBIT{1'b0}}
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_data_valid,
  input  logic [NBIT-1:0] i_mag,
  input  logic [1:0]      i_dir,
  output logic            o_ready,
  output logic            o_data_valid,
  output logic [NBIT-1:0] o_mag,
  output logic            o_last
);

  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int FL_W   = $clog2(IMG_WIDTH + 1);
  localparam int WARM_W = $clog2(IMG_WIDTH + 2);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(IMG_WIDTH);
  localparam logic [WARM_W-1:0] WARM_FULL = WARM_W'(IMG_WIDTH + 1);

`ifdef NMS_THRESH_EN
  localparam logic THRESH_ON = 1'b1;
`else
  localparam logic THRESH_ON = 1'b0;
`endif
  // A zero floor makes the threshold compare always true, i.e. disabled.
  localparam logic [NBIT-1:0] FLOOR = LOW_THRESH & {NBIT{THRESH_ON}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_r, state_s;
  logic   ready_r;

  // Input-side position; in_col also addresses the line buffers on every beat.
  logic [COL_W-1:0]  in_col_r;
  logic [ROW_W-1:0]  in_row_r;
  logic [FL_W-1:0]   flush_cnt_r;
  logic [WARM_W-1:0] warm_r;

  // Output-side position, used for border detection.
  logic [COL_W-1:0]  out_col_r;
  logic [ROW_W-1:0]  out_row_r;

  // Line buffers: lb1 holds the previous line (mag+dir), lb2 the one before.
  logic [NBIT+1:0] lb1_mem [IMG_WIDTH];
  logic [NBIT-1:0] lb2_mem [IMG_WIDTH];

  // Window: columns 1 and 2 are registered, column 3 is the live tap column.
  logic [NBIT-1:0] top1_r, top2_r, mid1_r, mid2_r, bot1_r, bot2_r;
  logic [1:0]      mid_dir_r;

  logic            accept_s, flush_beat_s, beat_s, last_in_s, flush_done_s;
  logic            out_en_s, border_s, keep_s;
  logic [NBIT-1:0] beat_mag_s;
  logic [1:0]      beat_dir_s;
  logic [NBIT+1:0] tap1_s;
  logic [NBIT-1:0] tap2_s;
  logic [NBIT-1:0] ctr_s, nbr_a_s, nbr_b_s, res_s;

  assign o_ready      = ready_r;
  assign accept_s     = i_data_valid & ready_r & (state_r != FLUSH);
  assign flush_beat_s = (state_r == FLUSH);
  assign beat_s       = accept_s | flush_beat_s;
  assign last_in_s    = accept_s & (in_row_r == ROW_LAST) & (in_col_r == COL_LAST);
  assign flush_done_s = flush_beat_s & (flush_cnt_r == FL_LAST);
  assign out_en_s     = beat_s & (warm_r == WARM_FULL);
  assign tap1_s       = lb1_mem[in_col_r];
  assign tap2_s       = lb2_mem[in_col_r];

  // Beat payload: live pixel on accept, zero pixel during flush.
  always_comb begin
    beat_mag_s = {NBIT{1'b0}};
    beat_dir_s = 2'd0;
    if (accept_s) begin
      beat_mag_s = i_mag;
      beat_dir_s = i_dir;
    end else begin
      beat_mag_s = {NBIT{1'b0}};
      beat_dir_s = 2'd0;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (last_in_s) begin
          state_s = FLUSH;
        end else if (accept_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_in_s) begin
          state_s = FLUSH;
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        if (flush_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = FLUSH;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register and registered ready (low exactly while flushing).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s != FLUSH);
    end
  end

  // Input/flush position counters and pipeline warm-up counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_col_r    <= {COL_W{1'b0}};
      in_row_r    <= {ROW_W{1'b0}};
      flush_cnt_r <= {FL_W{1'b0}};
      warm_r      <= {WARM_W{1'b0}};
    end else if (beat_s) begin
      if (flush_done_s || in_col_r == COL_LAST) begin
        in_col_r <= {COL_W{1'b0}};
      end else begin
        in_col_r <= in_col_r + COL_W'(1);
      end
      if (accept_s && in_col_r == COL_LAST) begin
        in_row_r <= (in_row_r == ROW_LAST) ? {ROW_W{1'b0}} : in_row_r + ROW_W'(1);
      end
      if (flush_done_s) begin
        flush_cnt_r <= {FL_W{1'b0}};
      end else if (flush_beat_s) begin
        flush_cnt_r <= flush_cnt_r + FL_W'(1);
      end
      if (flush_done_s) begin
        warm_r <= {WARM_W{1'b0}};
      end else if (warm_r != WARM_FULL) begin
        warm_r <= warm_r + WARM_W'(1);
      end
    end
  end

  // Line-buffer writes: contents are intentionally not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (beat_s) begin
      lb1_mem[in_col_r] <= {beat_dir_s, beat_mag_s};
      lb2_mem[in_col_r] <= tap1_s[NBIT-1:0];
    end
  end

  // Window shift: taps slide in on the right on every beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      top1_r    <= {NBIT{1'b0}};
      top2_r    <= {NBIT{1'b0}};
      mid1_r    <= {NBIT{1'b0}};
      mid2_r    <= {NBIT{1'b0}};
      bot1_r    <= {NBIT{1'b0}};
      bot2_r    <= {NBIT{1'b0}};
      mid_dir_r <= 2'd0;
    end else if (beat_s) begin
      top1_r    <= top2_r;
      top2_r    <= tap2_s;
      mid1_r    <= mid2_r;
      mid2_r    <= tap1_s[NBIT-1:0];
      mid_dir_r <= tap1_s[NBIT+1:NBIT];
      bot1_r    <= bot2_r;
      bot2_r    <= beat_mag_s;
    end
  end

  // Neighbour pair along the gradient direction of the post-shift centre.
  always_comb begin
    ctr_s   = mid2_r;
    nbr_a_s = mid1_r;
    nbr_b_s = tap1_s[NBIT-1:0];
    case (mid_dir_r)
      2'd0: begin
        nbr_a_s = mid1_r;
        nbr_b_s = tap1_s[NBIT-1:0];
      end
      2'd1: begin
        nbr_a_s = tap2_s;
        nbr_b_s = bot1_r;
      end
      2'd2: begin
        nbr_a_s = top2_r;
        nbr_b_s = bot2_r;
      end
      2'd3: begin
        nbr_a_s = top1_r;
        nbr_b_s = beat_mag_s;
      end
      default: begin
        nbr_a_s = mid1_r;
        nbr_b_s = tap1_s[NBIT-1:0];
      end
    endcase
  end

  // Keep rule (>= earlier neighbour, > later neighbour) with border masking.
  always_comb begin
    border_s = (out_row_r == {ROW_W{1'b0}}) || (out_row_r == ROW_LAST) ||
               (out_col_r == {COL_W{1'b0}}) || (out_col_r == COL_LAST);
    keep_s   = (ctr_s >= nbr_a_s) && (ctr_s > nbr_b_s) && (ctr_s >= FLOOR);
    if (border_s || !keep_s) begin
      res_s = {NBIT{1'b0}};
    end else begin
      res_s = ctr_s;
    end
  end

  // Output position counters, advanced once per emitted pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_col_r <= {COL_W{1'b0}};
      out_row_r <= {ROW_W{1'b0}};
    end else if (out_en_s) begin
      if (out_col_r == COL_LAST) begin
        out_col_r <= {COL_W{1'b0}};
        out_row_r <= (out_row_r == ROW_LAST) ? {ROW_W{1'b0}} : out_row_r + ROW_W'(1);
      end else begin
        out_col_r <= out_col_r + COL_W'(1);
      end
    end
  end

  // Registered output stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data_valid <= 1'b0;
      o_mag        <= {NBIT{1'b0}};
      o_last       <= 1'b0;
    end else if (out_en_s) begin
      o_data_valid <= 1'b1;
      o_mag        <= res_s;
      o_last       <= (out_row_r == ROW_LAST) && (out_col_r == COL_LAST);
    end else begin
      o_data_valid <= 1'b0;
      o_last       <= 1'b0;
    end
  end

endmodule
